// File: rtl/lfo_gen_if.sv
// Control/sample bundle between the LFO and its driver/consumer.
// The driver side owns step, phase and shape controls; the LFO returns the sample and wrap.
interface lfo_gen_if #(
  parameter int N     = 8,
  parameter int ACC_W = 24
);
  logic             en;
  logic             nxt;
  logic [ACC_W-1:0] inc;
  logic [1:0]       mode;
  logic             sync;
  logic [N-1:0]     wav;
  logic             wrap;

  modport master (output en, nxt, inc, mode, sync, input  wav, wrap);
  modport slave  (input  en, nxt, inc, mode, sync, output wav, wrap);
endinterface

// File: rtl/lfo_gen.sv
// Phase-accumulator LFO: triangle / ramp up / ramp down / square, with phase sync,
// shape changes deferred to the phase-0 boundary, and a wrap pulse aligned with the phase-0 sample.
module lfo_gen #(
  parameter int N     = 8,
  parameter int ACC_W = 24
) (
  input  logic      clk,
  input  logic      rst,
  lfo_gen_if.slave  lfo
);
  typedef enum logic [1:0] {M_TRI = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_SQ = 2'b11} mode_e;

  logic [ACC_W-1:0] acc_q, acc_d;
  mode_e            cur_mode_q, cur_mode_d;
  logic [N-1:0]     wav_q, wav_d;
  logic [1:0]       wrap_pipe_q, wrap_pipe_d;

  logic             step;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [N:0]       p;
  logic [N-1:0]     r;

  assign step  = lfo.en & lfo.nxt;
  assign sum   = {1'b0, acc_q} + {1'b0, lfo.inc};
  assign carry = sum[ACC_W];

  always_comb begin
    acc_d       = acc_q;
    cur_mode_d  = cur_mode_q;
    wrap_pipe_d = {wrap_pipe_q[0], 1'b0};
    if (lfo.sync) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[ACC_W-1:0];
    end
    // Shape only switches on restart, while idle, or on the step that lands on phase 0.
    if (lfo.sync || !lfo.en || (step && carry)) begin
      cur_mode_d = mode_e'(lfo.mode);
    end
    wrap_pipe_d[0] = lfo.sync | (step & carry);
  end

  // Sample mapping reads the registered phase, so wav trails acc by one cycle.
  assign p = acc_q[ACC_W-1 -: N+1];
  assign r = acc_q[ACC_W-1 -: N];

  always_comb begin
    wav_d = '0;
    case (cur_mode_q)
      M_TRI:   wav_d = p[N] ? ~p[N-1:0] : p[N-1:0];
      M_UP:    wav_d = r;
      M_DN:    wav_d = ~r;
      M_SQ:    wav_d = acc_q[ACC_W-1] ? '0 : '1;
      default: wav_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      cur_mode_q  <= M_TRI;
      wav_q       <= '0;
      wrap_pipe_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cur_mode_q  <= cur_mode_d;
      wav_q       <= wav_d;
      wrap_pipe_q <= wrap_pipe_d;
    end
  end

  assign lfo.wav  = wav_q;
  assign lfo.wrap = wrap_pipe_q[1];
endmodule

// File: tb/tb_lfo_gen.sv
// Directed bench for lfo_gen at N=3, ACC_W=8; expected samples are queued as stimulus
// is applied and popped one cycle later when the matching output is due.
module tb_lfo_gen;
  localparam int N = 3;
  localparam int ACC_W = 8;

  typedef struct {
    bit         chk;
    logic [2:0] wav;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  exp_t sb[$];

  lfo_gen_if #(.N(N), .ACC_W(ACC_W)) bus ();
  lfo_gen #(.N(N), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .lfo(bus));

  always #5 clk = ~clk;

  logic [2:0] tri_tab [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
                               3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
  logic [2:0] up_tab [8]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] dn_tab [8]  = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
  logic [2:0] sq_tab [8]  = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
  logic [2:0] ph0_tab [4] = '{3'd0, 3'd0, 3'd7, 3'd7};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tot_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  // Inputs are already driven; queue this cycle's expectation, clock, then
  // compare the output that belongs to the previous cycle's inputs.
  task automatic cyc(input string tag, input bit chk, input logic [2:0] ew, input logic ewr);
    exp_t e;
    e.chk = chk; e.wav = ew; e.wrap = ewr;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) begin
        check({tag, ".wav"},  {5'd0, bus.wav}, {5'd0, e.wav});
        check({tag, ".wrap"}, {7'd0, bus.wrap}, {7'd0, e.wrap});
      end
    end
  endtask

  initial begin
    logic [2:0] v;
    bus.en = 1'b0; bus.nxt = 1'b0; bus.inc = 8'd16; bus.mode = 2'b00; bus.sync = 1'b0;

    // reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst.wav",  {5'd0, bus.wav}, 8'd0);
      check("rst.wrap", {7'd0, bus.wrap}, 8'd0);
    end
    rst = 1'b1;

    // disabled: nxt pulses must not move the phase
    bus.nxt = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle", 1'b1, 3'd0, 1'b0);

    // triangle, two periods, wrap on the second zero
    bus.en = 1'b1;
    for (int i = 0; i < 32; i++) cyc("tri", 1'b1, tri_tab[i % 16], (i % 16) == 15);

    // mode request mid-period lands only at the wrap
    for (int i = 0; i < 16; i++) begin
      if (i == 5) bus.mode = 2'b01;
      cyc("defer", 1'b1, tri_tab[i], i == 15);
    end
    for (int k = 1; k <= 8; k++) begin
      v = 3'(k / 2);
      cyc("defer.ramp", 1'b1, v, 1'b0);
    end

    // ramps and square at inc=32, each started by a sync that also carries nxt
    bus.inc = 8'd32;
    for (int m = 1; m < 4; m++) begin
      bus.mode = 2'(m); bus.sync = 1'b1;
      cyc("shape.sync", 1'b1, ph0_tab[m], 1'b1);
      bus.sync = 1'b0;
      for (int i = 0; i < 16; i++) begin
        v = (m == 1) ? up_tab[i % 8] : (m == 2) ? dn_tab[i % 8] : sq_tab[i % 8];
        cyc("shape", 1'b1, v, (i % 8) == 7);
      end
    end

    // sync mid-period beats the step and restarts the triangle
    bus.inc = 8'd16; bus.mode = 2'b00; bus.sync = 1'b1;
    cyc("sync0", 1'b1, 3'd0, 1'b1);
    bus.sync = 1'b0;
    for (int i = 0; i < 6; i++) cyc("sync.pre", 1'b1, tri_tab[i], 1'b0);
    bus.sync = 1'b1;
    cyc("sync.mid", 1'b1, 3'd0, 1'b1);
    bus.sync = 1'b0;
    for (int i = 0; i < 16; i++) cyc("sync.post", 1'b1, tri_tab[i], i == 15);

    // asynchronous reset between edges, released with mode input at 01
    for (int i = 0; i < 4; i++) cyc("pre.arst", 1'b1, tri_tab[i], 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst.wav",  {5'd0, bus.wav}, 8'd0);
    check("arst.wrap", {7'd0, bus.wrap}, 8'd0);
    sb.delete();
    bus.mode = 2'b01;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 15; i++) cyc("post.arst", 1'b1, tri_tab[i], 1'b0);
    cyc("flush", 1'b0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
